// File: rtl/trifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trifetch_pkg
// Description : Shared tryte/trit definitions and fetch-stage types.
// Revision    : 1.0
// ============================================================================
package trifetch_pkg;

    localparam int TRYTE_W = 18;
    localparam int TRITS   = 9;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_BAD  = 2'b10;

    localparam logic [TRYTE_W-1:0] TRYTE_MAX = 18'h15555;
    localparam logic [TRYTE_W-1:0] TRYTE_MIN = 18'h3FFFF;

    typedef logic [TRYTE_W-1:0] tryte_t;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    function automatic logic tryte_has_illegal(input tryte_t t);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < TRITS; i++) begin
            if (t[2*i +: 2] == TRIT_BAD) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Balanced-ternary conversion of a signed integer, LSB trit first.
    function automatic tryte_t util_int_to_tryte(input int value);
        int     v;
        int     r;
        tryte_t t;
        v = value;
        t = '0;
        for (int i = 0; i < TRITS; i++) begin
            r = v % 3;
            if (r < 0) begin
                r = r + 3;
            end
            if (r == 0) begin
                t[2*i +: 2] = TRIT_ZERO;
            end else if (r == 1) begin
                t[2*i +: 2] = TRIT_POS;
                v = v - 1;
            end else begin
                t[2*i +: 2] = TRIT_NEG;
                v = v + 1;
            end
            v = v / 3;
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tryte_inc.sv
`default_nettype none
// ============================================================================
// Module      : tryte_inc
// Description : Combinational 9-trit balanced-ternary incrementer (wraps).
// Revision    : 1.0
// ============================================================================
module tryte_inc
    import trifetch_pkg::*;
(
    input  logic [TRYTE_W-1:0] i_tryte,
    output logic [TRYTE_W-1:0] o_tryte
);

    always_comb begin
        logic w_carry;
        w_carry = 1'b1;
        o_tryte = i_tryte;
        for (int i = 0; i < TRITS; i++) begin
            if (w_carry) begin
                case (i_tryte[2*i +: 2])
                    TRIT_NEG: begin
                        o_tryte[2*i +: 2] = TRIT_ZERO;
                        w_carry           = 1'b0;
                    end
                    TRIT_ZERO: begin
                        o_tryte[2*i +: 2] = TRIT_POS;
                        w_carry           = 1'b0;
                    end
                    // +1 rolls to -1 and the carry ripples on
                    default: begin
                        o_tryte[2*i +: 2] = TRIT_NEG;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trifetch.sv
`default_nettype none
// ============================================================================
// Module      : trifetch
// Description : Ternary instruction fetch stage in front of triram.
//               Optional macro: TRIFETCH_ILLEGAL_TRIT_CHECK_EN.
// Revision    : 1.0
// ============================================================================
module trifetch
    import trifetch_pkg::*;
#(
    parameter logic [TRYTE_W-1:0] RESET_PC = 18'h0,
    parameter logic signed [1:0]  FETCH_PT = 2'sb01
)
(
    input  logic                clk,
    input  logic                rst,
    output logic                ram_e,
    output logic                ram_write,
    output logic signed [1:0]   ram_pt,
    output logic [TRYTE_W-1:0]  ram_addr,
    input  logic                ram_o,
    input  logic                ram_pagefault,
    input  logic [TRYTE_W-1:0]  ram_out,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [TRYTE_W-1:0]  instr,
    output logic [TRYTE_W-1:0]  instr_pc,
    input  logic                redir,
    input  logic [TRYTE_W-1:0]  redir_pc,
    output logic                fault,
`ifdef TRIFETCH_ILLEGAL_TRIT_CHECK_EN
    output logic                illegal,
`endif
    output logic [TRYTE_W-1:0]  fault_addr
);

    fetch_state_t       r_state, w_state_nxt;
    logic [TRYTE_W-1:0] r_pc, w_pc_nxt;
    logic               r_drop, w_drop_nxt;
    logic               r_ram_e, w_ram_e_nxt;
    logic               r_valid, w_valid_nxt;
    logic [TRYTE_W-1:0] r_instr, w_instr_nxt;
    logic [TRYTE_W-1:0] r_instr_pc, w_instr_pc_nxt;
    logic               r_fault, w_fault_nxt;
    logic [TRYTE_W-1:0] r_fault_addr, w_fault_addr_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic [TRYTE_W-1:0] w_pc_inc;
    logic               w_illegal_resp;

    tryte_inc u_pc_inc (
        .i_tryte (r_pc),
        .o_tryte (w_pc_inc)
    );

`ifdef TRIFETCH_ILLEGAL_TRIT_CHECK_EN
    assign w_illegal_resp = tryte_has_illegal(ram_out);
    assign illegal        = r_illegal;
`else
    assign w_illegal_resp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_ram_e      <= 1'b0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_ram_e      <= w_ram_e_nxt;
            r_valid      <= w_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_instr_pc   <= w_instr_pc_nxt;
            r_fault      <= w_fault_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            r_illegal    <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_nxt       = r_drop;
        w_ram_e_nxt      = 1'b0;
        w_valid_nxt      = r_valid;
        w_instr_nxt      = r_instr;
        w_instr_pc_nxt   = r_instr_pc;
        w_fault_nxt      = r_fault;
        w_fault_addr_nxt = r_fault_addr;
        w_illegal_nxt    = r_illegal;

        if (redir) begin
            w_pc_nxt      = redir_pc;
            w_valid_nxt   = 1'b0;
            w_fault_nxt   = 1'b0;
            w_illegal_nxt = 1'b0;
            // An in-flight request must still be drained before reissuing
            if ((r_state == ST_WAIT) && !ram_o) begin
                w_state_nxt = ST_WAIT;
                w_drop_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_REQ;
                w_drop_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    w_ram_e_nxt = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (ram_o) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = ST_REQ;
                        end else if (ram_pagefault || w_illegal_resp) begin
                            w_fault_nxt      = 1'b1;
                            w_fault_addr_nxt = r_pc;
                            w_illegal_nxt    = !ram_pagefault;
                            w_state_nxt      = ST_FAULT;
                        end else begin
                            w_instr_nxt    = ram_out;
                            w_instr_pc_nxt = r_pc;
                            w_valid_nxt    = 1'b1;
                            w_pc_nxt       = w_pc_inc;
                            w_state_nxt    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_FAULT: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end
    end

    assign ram_e       = r_ram_e;
    assign ram_write   = 1'b0;
    assign ram_pt      = FETCH_PT;
    assign ram_addr    = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_trifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_trifetch
// Description : Directed self-checking bench for trifetch; the bench plays triram.
// Revision    : 1.0
// ============================================================================
module tb_trifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_e;
    logic        ram_write;
    logic signed [1:0] ram_pt;
    logic [17:0] ram_addr;
    logic        ram_o = 1'b0;
    logic        ram_pagefault = 1'b0;
    logic [17:0] ram_out = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [17:0] instr;
    logic [17:0] instr_pc;
    logic        redir = 1'b0;
    logic [17:0] redir_pc = '0;
    logic        fault;
    logic [17:0] fault_addr;
`ifdef TRIFETCH_ILLEGAL_TRIT_CHECK_EN
    logic        illegal;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed balanced-ternary addresses
    localparam logic [17:0] T_0    = 18'h00000;
    localparam logic [17:0] T_1    = 18'h00001;
    localparam logic [17:0] T_4    = 18'h00005;
    localparam logic [17:0] T_5    = 18'h0001F;
    localparam logic [17:0] T_697  = 18'h010F5;
    localparam logic [17:0] T_1916 = 18'h04CC3;
    localparam logic [17:0] T_MAX  = 18'h15555;
    localparam logic [17:0] T_MIN  = 18'h3FFFF;

    trifetch dut (
        .clk           (clk),
        .rst           (rst),
        .ram_e         (ram_e),
        .ram_write     (ram_write),
        .ram_pt        (ram_pt),
        .ram_addr      (ram_addr),
        .ram_o         (ram_o),
        .ram_pagefault (ram_pagefault),
        .ram_out       (ram_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redir         (redir),
        .redir_pc      (redir_pc),
        .fault         (fault),
`ifdef TRIFETCH_ILLEGAL_TRIT_CHECK_EN
        .illegal       (illegal),
`endif
        .fault_addr    (fault_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic [17:0] data, input logic pf);
        ram_o         = 1'b1;
        ram_out       = data;
        ram_pagefault = pf;
        @(negedge clk);
        ram_o         = 1'b0;
        ram_out       = '0;
        ram_pagefault = 1'b0;
    endtask

    task automatic redirect(input logic [17:0] pc);
        redir    = 1'b1;
        redir_pc = pc;
        @(negedge clk);
        redir    = 1'b0;
    endtask

    // Entered with the DUT in REQ; leaves it in REQ after a completed handshake.
    task automatic fetch_at(input logic [17:0] pc, input logic [17:0] data, input logic [17:0] nxt);
        redirect(pc);
        chk1("redir_no_req", ram_e, 1'b0);
        chk("redir_addr", ram_addr, pc);
        @(negedge clk);
        chk1("req_e", ram_e, 1'b1);
        chk("req_addr", ram_addr, pc);
        respond(data, 1'b0);
        chk1("fetch_valid", instr_valid, 1'b1);
        chk("fetch_instr", instr, data);
        chk("fetch_pc", instr_pc, pc);
        chk("next_addr", ram_addr, nxt);
        @(negedge clk);
        chk1("handshake_clr", instr_valid, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk1("rst_ram_e", ram_e, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_addr", ram_addr, T_0);
        chk("rst_instr", instr, 18'h0);
        chk("rst_fault_addr", fault_addr, 18'h0);
        chk1("ram_write", ram_write, 1'b0);
        chk("ram_pt", {16'h0, ram_pt}, 18'h00001);

        // First fetch from RESET_PC
        rst = 1'b0;
        @(negedge clk);
        chk1("first_req", ram_e, 1'b1);
        chk("first_addr", ram_addr, T_0);
        respond(18'h3F000, 1'b0);
        chk1("first_valid", instr_valid, 1'b1);
        chk("first_instr", instr, 18'h3F000);
        chk("first_pc", instr_pc, T_0);
        chk("first_next", ram_addr, T_1);
        chk1("first_no_req", ram_e, 1'b0);
        @(negedge clk);
        chk1("first_clr", instr_valid, 1'b0);

        // Redirect-and-fetch, including wraparound at the top of the range
        fetch_at(T_4, 18'h0F0F3, T_5);
        fetch_at(T_MAX, 18'h15551, T_MIN);

        // Page fault is sticky until redirected
        redirect(T_697);
        chk1("pf_redir_no_req", ram_e, 1'b0);
        @(negedge clk);
        chk1("pf_req", ram_e, 1'b1);
        chk("pf_req_addr", ram_addr, T_697);
        respond(18'h2AAAA, 1'b1);
        chk1("pf_fault", fault, 1'b1);
        chk("pf_fault_addr", fault_addr, T_697);
        chk1("pf_valid", instr_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("pf_idle_e", ram_e, 1'b0);
            chk1("pf_idle_valid", instr_valid, 1'b0);
            chk1("pf_sticky", fault, 1'b1);
        end
        redirect(T_0);
        chk1("pf_clear", fault, 1'b0);
        chk1("pf_clear_no_req", ram_e, 1'b0);
        @(negedge clk);
        chk1("pf_resume_req", ram_e, 1'b1);
        chk("pf_resume_addr", ram_addr, T_0);

        // Backpressure in HOLD
        instr_ready = 1'b0;
        respond(18'h33333, 1'b0);
        chk1("hold_valid0", instr_valid, 1'b1);
        chk("hold_next", ram_addr, T_1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("hold_valid", instr_valid, 1'b1);
            chk("hold_instr", instr, 18'h33333);
            chk("hold_pc", instr_pc, T_0);
            chk1("hold_no_req", ram_e, 1'b0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk1("hold_release", instr_valid, 1'b0);
        chk1("hold_release_e", ram_e, 1'b0);
        @(negedge clk);
        chk1("hold_new_req", ram_e, 1'b1);
        chk("hold_new_addr", ram_addr, T_1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("single_req", ram_e, 1'b0);
        end

        // Redirect while waiting; response arrives two cycles later and is dropped
        redirect(T_1916);
        chk1("drop_valid", instr_valid, 1'b0);
        chk1("drop_no_req", ram_e, 1'b0);
        chk("drop_addr", ram_addr, T_1916);
        @(negedge clk);
        chk1("drop_wait", ram_e, 1'b0);
        respond(18'h00001, 1'b0);
        chk1("dropped_valid", instr_valid, 1'b0);
        chk1("dropped_no_req", ram_e, 1'b0);
        @(negedge clk);
        chk1("drop_reissue", ram_e, 1'b1);
        chk("drop_reissue_addr", ram_addr, T_1916);
        chk1("drop_reissue_valid", instr_valid, 1'b0);

        // Redirect and response in the same cycle
        ram_o    = 1'b1;
        ram_out  = 18'h00001;
        redir    = 1'b1;
        redir_pc = T_MAX;
        @(negedge clk);
        ram_o    = 1'b0;
        redir    = 1'b0;
        chk1("same_valid", instr_valid, 1'b0);
        chk1("same_no_req", ram_e, 1'b0);
        chk1("same_no_fault", fault, 1'b0);
        chk("same_addr", ram_addr, T_MAX);
        @(negedge clk);
        chk1("same_reissue", ram_e, 1'b1);
        chk("same_reissue_addr", ram_addr, T_MAX);
        respond(18'h0F0F3, 1'b0);
        chk1("same_fetch_valid", instr_valid, 1'b1);
        chk("same_fetch_pc", instr_pc, T_MAX);
        chk("same_fetch_next", ram_addr, T_MIN);

        // Redirect beats a handshake in HOLD
        redirect(T_1);
        chk1("flush_valid", instr_valid, 1'b0);
        chk1("flush_no_req", ram_e, 1'b0);
        chk("flush_addr", ram_addr, T_1);
        @(negedge clk);
        chk1("flush_req", ram_e, 1'b1);
        chk("flush_req_addr", ram_addr, T_1);

        // Asynchronous reset during WAIT
        rst = 1'b1;
        #1;
        chk1("async_rst_e", ram_e, 1'b0);
        chk("async_rst_addr", ram_addr, T_0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_req", ram_e, 1'b1);
        chk("post_rst_addr", ram_addr, T_0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
